// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the boot-time instruction loader.
//   state_e        loader FSM states (also exported on the debug port)
//   LEN_BYTES      bytes of the little-endian word-count header
//   BYTES_PER_WORD bytes packed into one instruction word
//   exceeds_depth  true when a declared word count will not fit in memory
package imem_loader_pkg;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // 17-bit compare so a depth of 2^16 words is still representable.
  function automatic logic exceeds_depth(input logic [15:0] n, input int aw);
    return {1'b0, n} > (17'd1 << aw);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs bytes into a 32-bit little-endian word.
//   clk, rst          clock, async active-high reset
//   data_i            incoming byte
//   accept_i          byte is transferred this cycle
//   clear_i           restart at byte 0 (takes priority over accept_i)
//   word_o            assembled word (registered)
//   word_complete_o   the byte accepted this cycle completes a word
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        accept_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (accept_i) begin
      // Byte lane selected by the index: first byte lands in bits [7:0].
      word_d[idx_q*8 +: 8] = data_i;
      idx_d                = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o          = word_q;
  assign word_complete_o = accept_i && !clear_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Receives "N (16-bit LE), then N
// 32-bit LE words" as a byte stream and writes the words to instruction
// memory, holding the core in reset until the load completes.
//   clk, rst        clock, async active-high reset
//   start           one-cycle pulse, re-arms a load (only honoured in DONE)
//   in_valid/in_data/in_ready   byte stream input
//   imem_we/imem_addr/imem_wdata instruction-memory write port
//   core_hold       high while the core must stay in reset
//   done            load finished
//   err             declared length exceeded memory depth
//   words_loaded    words received in the current load
//   state_dbg       current FSM state, for observation only
//
// Handshake: a byte transfers at a rising edge where in_valid && in_ready.
// in_ready depends only on registered state, never on in_valid; the source
// must hold in_valid/in_data stable until the transfer happens.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_loaded,
  output state_e                state_dbg
);

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  state_e      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] len_q, len_d;
  logic [15:0] words_q, words_d;
  logic        err_q, err_d;

  logic        accept;
  logic        asm_accept;
  logic        asm_clear;
  logic        word_complete;
  logic [15:0] len_in;

  assign accept     = in_valid && in_ready;
  assign asm_accept = accept && (state_q == DATA);
  assign asm_clear  = (state_q == DONE) && start;
  assign len_in     = {in_data, len_lo_q};

  word_assembler u_asm (
    .clk             (clk),
    .rst             (rst),
    .data_i          (in_data),
    .accept_i        (asm_accept),
    .clear_i         (asm_clear),
    .word_o          (imem_wdata),
    .word_complete_o (word_complete)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    words_d  = words_q;
    err_d    = err_q;
    case (state_q)
      LEN_LO: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d   = len_in;
          state_d = (len_in == 16'd0) ? DONE : DATA;
          if (exceeds_depth(len_in, ADDR_WIDTH)) err_d = 1'b1;
        end
      end
      DATA: begin
        if (word_complete) state_d = WRITE;
      end
      WRITE: begin
        words_d = words_q + 16'd1;
        state_d = (words_q + 16'd1 == len_q) ? DONE : DATA;
      end
      DONE: begin
        if (start) begin
          state_d = LEN_LO;
          words_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = LEN_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LEN_LO;
      len_lo_q <= '0;
      len_q    <= '0;
      words_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      words_q  <= words_d;
      err_q    <= err_d;
    end
  end

  // Outputs are pure decodes of registers. Words past the memory depth still
  // go through WRITE (to keep the stream consumed) but with the strobe low.
  assign in_ready     = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
  assign imem_we      = (state_q == WRITE) && ({1'b0, words_q} < DEPTH);
  assign imem_addr    = words_q[ADDR_WIDTH-1:0];
  assign core_hold    = (state_q != DONE);
  assign done         = (state_q == DONE);
  assign err          = err_q;
  assign words_loaded = words_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  always #5 clk = ~clk;

  // Large instance (1024 words) and small instance (4 words) share stimulus.
  logic        rdy_b, we_b, hold_b, done_b, err_b;
  logic [9:0]  addr_b;
  logic [31:0] wdata_b;
  logic [15:0] wl_b;
  state_e      st_b;
  logic        rdy_s, we_s, hold_s, done_s, err_s;
  logic [1:0]  addr_s;
  logic [31:0] wdata_s;
  logic [15:0] wl_s;
  state_e      st_s;

  imem_loader #(.ADDR_WIDTH(10)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .core_hold(hold_b), .done(done_b), .err(err_b), .words_loaded(wl_b),
    .state_dbg(st_b)
  );

  imem_loader #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_s), .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s),
    .core_hold(hold_s), .done(done_s), .err(err_s), .words_loaded(wl_s),
    .state_dbg(st_s)
  );

  // ---------------- scoreboard ----------------
  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_rdy = 1'b0;
  logic [47:0] wr_b[$], wr_s[$];
  logic [47:0] exp_b[$], exp_s[$];
  logic [31:0] wq[0:7];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Memory-side observer: log every strobed write as {addr, data}.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      if (we_b === 1'b1) wr_b.push_back({6'd0, addr_b, wdata_b});
      if (we_s === 1'b1) wr_s.push_back({14'd0, addr_s, wdata_s});
    end
  end

  // With every word in range, the loader stalls the stream only while writing.
  always @(negedge clk) begin
    if (chk_rdy && rst === 1'b0)
      chk("ready_low_only_in_write", 64'(!rdy_b && !done_b), 64'(we_b));
  end

  task automatic check_writes(input string tag);
    chk({tag, "_nwr_big"}, 64'(wr_b.size()), 64'(exp_b.size()));
    chk({tag, "_nwr_small"}, 64'(wr_s.size()), 64'(exp_s.size()));
    for (int i = 0; i < wr_b.size() && i < exp_b.size(); i++)
      chk({tag, "_wr_big"}, 64'(wr_b[i]), 64'(exp_b[i]));
    for (int i = 0; i < wr_s.size() && i < exp_s.size(); i++)
      chk({tag, "_wr_small"}, 64'(wr_s[i]), 64'(exp_s[i]));
    wr_b.delete(); wr_s.delete(); exp_b.delete(); exp_s.delete();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, 64'(rdy_b), 1);   chk({tag, "_ready_s"}, 64'(rdy_s), 1);
    chk({tag, "_we"}, 64'(we_b), 0);       chk({tag, "_we_s"}, 64'(we_s), 0);
    chk({tag, "_addr"}, 64'(addr_b), 0);   chk({tag, "_wdata"}, 64'(wdata_b), 0);
    chk({tag, "_hold"}, 64'(hold_b), 1);   chk({tag, "_hold_s"}, 64'(hold_s), 1);
    chk({tag, "_done"}, 64'(done_b), 0);   chk({tag, "_done_s"}, 64'(done_s), 0);
    chk({tag, "_err"}, 64'(err_b), 0);     chk({tag, "_err_s"}, 64'(err_s), 0);
    chk({tag, "_words"}, 64'(wl_b), 0);    chk({tag, "_state"}, 64'(st_b), 64'(LEN_LO));
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int t;
    if (rnd) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (rdy_b !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("accept_within_budget", 64'(t < 20), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_hold"}, 64'(hold_b), 1);  chk({tag, "_done"}, 64'(done_b), 0);
    chk({tag, "_ready"}, 64'(rdy_b), 1); chk({tag, "_err_s"}, 64'(err_s), 0);
    chk({tag, "_words"}, 64'(wl_b), 0);
  endtask

  // Reference: word i goes to address i while i < depth; later words vanish.
  task automatic run_load(input string tag, input int n, input bit rnd, input bit poke);
    for (int i = 0; i < n; i++) begin
      exp_b.push_back({16'(i), wq[i]});
      if (i < 4) exp_s.push_back({16'(i), wq[i]});
    end
    send_byte(8'(n), rnd);
    send_byte(8'(n >> 8), rnd);
    chk({tag, "_err_big"}, 64'(err_b), 64'(n > 1024));
    chk({tag, "_err_small"}, 64'(err_s), 64'(n > 4));
    if (n == 0) begin
      chk({tag, "_n0_done"}, 64'(done_b), 1);
      chk({tag, "_n0_hold"}, 64'(hold_b), 0);
    end else begin
      chk({tag, "_busy_done"}, 64'(done_b), 0);
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        send_byte(wq[i][8*j +: 8], rnd);
        if (poke && i == 0 && j == 1) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          chk({tag, "_start_ignored"}, 64'(st_b), 64'(DATA));
          chk({tag, "_start_ignored_hold"}, 64'(hold_b), 1);
        end
      end
    end
    if (n > 0) begin
      chk({tag, "_last_we"}, 64'(we_b), 1);
      chk({tag, "_last_done"}, 64'(done_b), 0);
      chk({tag, "_last_hold"}, 64'(hold_b), 1);
      @(negedge clk);
      chk({tag, "_done"}, 64'(done_b), 1);   chk({tag, "_done_s"}, 64'(done_s), 1);
      chk({tag, "_hold"}, 64'(hold_b), 0);   chk({tag, "_hold_s"}, 64'(hold_s), 0);
      chk({tag, "_we_after"}, 64'(we_b), 0);
    end
    chk({tag, "_words_big"}, 64'(wl_b), 64'(n));
    chk({tag, "_words_small"}, 64'(wl_s), 64'(n));
    check_writes(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    #2 rst = 1'b1;                     // mid-cycle, before any clock edge
    #1 chk_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_rdy = 1'b1;
    chk_reset_values("after_reset");

    // Two known instructions, no gaps.
    wq[0] = 32'h0010_0513; wq[1] = 32'h0020_0593;
    run_load("n2", 2, 1'b0, 1'b0);

    // Random words with random valid gaps.
    pulse_start("start1");
    for (int i = 0; i < 3; i++) wq[i] = $urandom;
    run_load("n3_bp", 3, 1'b1, 1'b0);

    pulse_start("start2");
    run_load("n0", 0, 1'b0, 1'b0);

    // Overflows the 4-word instance only.
    pulse_start("start3");
    for (int i = 0; i < 5; i++) wq[i] = $urandom;
    run_load("n5_ovf", 5, 1'b1, 1'b0);
    chk("ovf_err_held", 64'(err_s), 1);

    pulse_start("start4");
    wq[0] = 32'hDEAD_BEEF;
    run_load("reload", 1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle while in DONE.
    #2 rst = 1'b1;
    #1 chk_reset_values("rst_in_done");
    @(negedge clk);
    rst = 1'b0;

    // Reset after 6 data bytes of a 2-word load: only word 0 survives.
    wq[0] = $urandom; wq[1] = $urandom;
    exp_b.push_back({16'd0, wq[0]});
    exp_s.push_back({16'd0, wq[0]});
    send_byte(8'd2, 1'b1);
    send_byte(8'd0, 1'b1);
    for (int j = 0; j < 6; j++) send_byte((j < 4) ? wq[0][8*j +: 8] : wq[1][8*(j-4) +: 8], 1'b1);
    rst = 1'b1;
    #1 chk_reset_values("rst_partial");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_writes("partial");
    chk("partial_state", 64'(st_b), 64'(LEN_LO));

    // Fresh load straight out of reset with backpressure.
    for (int i = 0; i < 3; i++) wq[i] = $urandom;
    run_load("post_rst", 3, 1'b1, 1'b0);

    chk_rdy = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
